// File: rtl/core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// core_mem_arbiter
//
// Shares one single-outstanding memory port between the instruction-fetch side
// and the load/store side of the core. Each side holds its request until its
// stall drops. The arbiter turns that into a registered valid/ready bus request
// followed by a response. Data has priority over fetch, but a waiting fetch
// gets the bus after STARVE_LIMIT consecutive data grants. A response that
// does not arrive within TIMEOUT cycles completes with an error and zero data.
//
// Parameters
//   STARVE_LIMIT  consecutive data grants allowed while fetch waits (1..15)
//   TIMEOUT       response-wait cycles before forced error completion (1..255)
//
// Ports
//   clk, reset                      clock, synchronous active-low reset
//   if_req/if_addr                  fetch request (held while if_stall=1)
//   if_rdata/if_stall/if_fault      fetch result, stall and access fault
//   d_req/d_we/d_addr/d_wdata/d_wmask  load/store request (held while d_stall=1)
//   d_rdata/d_stall/d_err           load data, stall and bus error
//   m_req_valid/m_req_ready         bus request handshake
//   m_we/m_addr/m_wdata/m_wmask     registered bus request fields
//   m_rsp_valid/m_rdata/m_rsp_err   bus response (always accepted in RSP)
// -----------------------------------------------------------------------------
module core_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  output logic        if_fault,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        d_err,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wmask,
  input  logic        m_rsp_valid,
  input  logic [31:0] m_rdata,
  input  logic        m_rsp_err
);

  localparam logic [3:0] STARVE_LIM  = 4'(STARVE_LIMIT);
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  // Transaction bookkeeping
  logic        owner_data_r;   // 1 = load/store side owns the bus, 0 = fetch
  logic        cancel_r;       // owner dropped its request mid-transaction
  logic [3:0]  run_cnt_r;      // consecutive data grants while fetch waited
  logic [7:0]  tmo_cnt_r;      // response-wait cycles spent in RSP

  // Registered bus request
  logic        m_req_valid_r;
  logic        m_we_r;
  logic [31:0] m_addr_r;
  logic [31:0] m_wdata_r;
  logic [3:0]  m_wmask_r;

  // Registered per-side results
  logic [31:0] if_rdata_r;
  logic        if_fault_r;
  logic [31:0] d_rdata_r;
  logic        d_err_r;

  // Decoded control
  logic        grant_fetch_s;
  logic        grant_data_s;
  logic        owner_req_s;
  logic        rsp_take_s;
  logic        tmo_hit_s;
  logic        deliver_s;
  logic        done_live_s;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_fetch_s || grant_data_s) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (m_req_ready) begin
          state_next_s = RSP;
        end else begin
          state_next_s = REQ;
        end
      end
      RSP: begin
        if (m_rsp_valid || (tmo_cnt_r == TIMEOUT_LIM)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RSP;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output/control decode: arbitration, completion and stall generation
  always_comb begin
    grant_fetch_s = 1'b0;
    grant_data_s  = 1'b0;
    if (state_r == IDLE) begin
      // Fetch wins when alone, or when data has hogged the bus long enough.
      if (if_req && (!d_req || (run_cnt_r == STARVE_LIM))) begin
        grant_fetch_s = 1'b1;
      end else if (d_req) begin
        grant_data_s = 1'b1;
      end else begin
        grant_data_s = 1'b0;
      end
    end else begin
      grant_fetch_s = 1'b0;
    end

    owner_req_s = owner_data_r ? d_req : if_req;
    rsp_take_s  = (state_r == RSP) && m_rsp_valid;
    tmo_hit_s   = (state_r == RSP) && !m_rsp_valid && (tmo_cnt_r == TIMEOUT_LIM);

    // A completion only reaches the owner if it kept its request up the
    // whole way; otherwise the transaction drains silently.
    deliver_s   = (rsp_take_s || tmo_hit_s) && owner_req_s && !cancel_r;
    done_live_s = (state_r == DONE) && !cancel_r;

    if_stall    = if_req && !(done_live_s && !owner_data_r);
    d_stall     = d_req  && !(done_live_s &&  owner_data_r);
  end

  // Bus request register: fields captured at grant, valid held through REQ
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_req_valid_r <= 1'b0;
      m_we_r        <= 1'b0;
      m_addr_r      <= 32'h0000_0000;
      m_wdata_r     <= 32'h0000_0000;
      m_wmask_r     <= 4'h0;
      owner_data_r  <= 1'b0;
    end else if (grant_data_s) begin
      m_req_valid_r <= 1'b1;
      m_we_r        <= d_we;
      m_addr_r      <= d_addr;
      m_wdata_r     <= d_wdata;
      m_wmask_r     <= d_wmask;
      owner_data_r  <= 1'b1;
    end else if (grant_fetch_s) begin
      m_req_valid_r <= 1'b1;
      m_we_r        <= 1'b0;
      m_addr_r      <= if_addr;
      m_wdata_r     <= 32'h0000_0000;
      m_wmask_r     <= 4'h0;
      owner_data_r  <= 1'b0;
    end else if ((state_r == REQ) && m_req_ready) begin
      m_req_valid_r <= 1'b0;
    end else begin
      m_req_valid_r <= m_req_valid_r;
    end
  end

  // Cancellation tracking: sticky once the owner lets go before DONE
  always_ff @(posedge clk) begin
    if (!reset) begin
      cancel_r <= 1'b0;
    end else if (grant_data_s || grant_fetch_s) begin
      cancel_r <= 1'b0;
    end else if ((state_r == REQ) || (state_r == RSP)) begin
      cancel_r <= cancel_r || !owner_req_s;
    end else begin
      cancel_r <= cancel_r;
    end
  end

  // Starvation counter: counts data grants that overtook a waiting fetch
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_cnt_r <= 4'd0;
    end else if (grant_data_s) begin
      if (!if_req) begin
        run_cnt_r <= 4'd0;
      end else if (run_cnt_r != 4'hF) begin
        run_cnt_r <= run_cnt_r + 4'd1;
      end else begin
        run_cnt_r <= run_cnt_r;
      end
    end else if (grant_fetch_s) begin
      run_cnt_r <= 4'd0;
    end else begin
      run_cnt_r <= run_cnt_r;
    end
  end

  // Response timeout counter: zero on RSP entry, counts idle RSP cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt_r <= 8'd0;
    end else if (state_r == REQ) begin
      tmo_cnt_r <= 8'd0;
    end else if ((state_r == RSP) && !m_rsp_valid && (tmo_cnt_r != TIMEOUT_LIM)) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Per-side result registers: written on a delivered completion, flags
  // cleared when the FSM returns to IDLE
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_rdata_r <= 32'h0000_0000;
      if_fault_r <= 1'b0;
      d_rdata_r  <= 32'h0000_0000;
      d_err_r    <= 1'b0;
    end else if (deliver_s) begin
      if (owner_data_r) begin
        d_rdata_r <= rsp_take_s ? m_rdata : 32'h0000_0000;
        d_err_r   <= rsp_take_s ? m_rsp_err : 1'b1;
      end else begin
        if_rdata_r <= rsp_take_s ? m_rdata : 32'h0000_0000;
        if_fault_r <= rsp_take_s ? m_rsp_err : 1'b1;
      end
    end else if (state_r == DONE) begin
      if_fault_r <= 1'b0;
      d_err_r    <= 1'b0;
    end else begin
      if_fault_r <= if_fault_r;
      d_err_r    <= d_err_r;
    end
  end

  assign m_req_valid = m_req_valid_r;
  assign m_we        = m_we_r;
  assign m_addr      = m_addr_r;
  assign m_wdata     = m_wdata_r;
  assign m_wmask     = m_wmask_r;
  assign if_rdata    = if_rdata_r;
  assign if_fault    = if_fault_r;
  assign d_rdata     = d_rdata_r;
  assign d_err       = d_err_r;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_core_mem_arbiter
//
// Scoreboard bench for core_mem_arbiter (STARVE_LIMIT=4, TIMEOUT=8).
// Tests push the bus requests and completions they expect into queues; a
// monitor pops and compares whenever the DUT hands off a bus request or
// releases a side's stall. A small bus slave answers accepted requests one
// cycle later from a response queue, or stays silent when muted.
// -----------------------------------------------------------------------------
module tb_core_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } bus_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
  } cpl_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        if_fault;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        d_err;
  logic        m_req_valid;
  logic        m_req_ready;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic        m_rsp_valid;
  logic [31:0] m_rdata;
  logic        m_rsp_err;

  bus_t        exp_bus_q[$];
  cpl_t        exp_if_q[$];
  cpl_t        exp_d_q[$];
  rsp_t        bus_rsp_q[$];
  logic [31:0] if_vec_q[$];
  bus_t        d_vec_q[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   if_done_cyc = 0;
  int   d_done_cyc = 0;
  int   t0 = 0;
  int   stale_cnt = 0;
  bit   rsp_mute = 1'b0;
  logic acc_r = 1'b0;

  core_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_stall(if_stall), .if_fault(if_fault),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_stall(d_stall), .d_err(d_err),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rsp_valid(m_rsp_valid), .m_rdata(m_rdata), .m_rsp_err(m_rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) acc_r <= m_req_valid & m_req_ready;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  function automatic bus_t mk_bus(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] wmask);
    bus_t b;
    b.we = we; b.addr = addr; b.wdata = wdata; b.wmask = wmask;
    return b;
  endfunction

  function automatic cpl_t mk_cpl(input logic [31:0] rdata, input logic err, input logic chk_rdata);
    cpl_t c;
    c.rdata = rdata; c.err = err; c.chk_rdata = chk_rdata;
    return c;
  endfunction

  function automatic rsp_t mk_rsp(input logic [31:0] data, input logic err);
    rsp_t r;
    r.data = data; r.err = err;
    return r;
  endfunction

  // Bus slave: answers each accepted request in the next cycle; otherwise
  // emits a stale response pulse when a test asks for one.
  initial begin
    rsp_t r;
    int   stale_done;
    stale_done  = 0;
    m_rsp_valid = 1'b0;
    m_rdata     = 32'h0000_0000;
    m_rsp_err   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_rsp_valid = 1'b0;
      m_rsp_err   = 1'b0;
      if (acc_r && !rsp_mute) begin
        if (bus_rsp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL slave_rsp: no response queued for accepted request, required one");
        end else begin
          r = bus_rsp_q.pop_front();
          m_rsp_valid = 1'b1;
          m_rdata     = r.data;
          m_rsp_err   = r.err;
        end
      end else if (stale_cnt != stale_done) begin
        stale_done++;
        m_rsp_valid = 1'b1;
        m_rdata     = 32'hBAD0_BAD0;
        m_rsp_err   = 1'b1;
      end
    end
  end

  // Monitor: compares bus requests and side completions against the queues
  initial begin
    bus_t b;
    cpl_t c;
    forever begin
      @(negedge clk);
      if (m_req_valid && m_req_ready) begin
        if (exp_bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_unexpected: got request addr 0x%08h, required none", m_addr);
        end else begin
          b = exp_bus_q.pop_front();
          chk1("bus_we", m_we, b.we);
          chk32("bus_addr", m_addr, b.addr);
          chk32("bus_wdata", m_wdata, b.wdata);
          chk32("bus_wmask", {28'd0, m_wmask}, {28'd0, b.wmask});
        end
      end
      if (if_req && !if_stall) begin
        if (exp_if_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL if_unexpected: got fetch completion 0x%08h, required none", if_rdata);
        end else begin
          c = exp_if_q.pop_front();
          chk32("if_rdata", if_rdata, c.rdata);
          chk1("if_fault", if_fault, c.err);
        end
      end
      if (d_req && !d_stall) begin
        if (exp_d_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL d_unexpected: got data completion 0x%08h, required none", d_rdata);
        end else begin
          c = exp_d_q.pop_front();
          if (c.chk_rdata) chk32("d_rdata", d_rdata, c.rdata);
          chk1("d_err", d_err, c.err);
        end
      end
    end
  end

  // Presents queued fetch addresses back to back, each held until done.
  task automatic run_fetch_side();
    int guard;
    while (if_vec_q.size() > 0) begin
      if_addr = if_vec_q.pop_front();
      if_req  = 1'b1;
      guard   = 0;
      @(negedge clk);
      while (if_stall && guard < 100) begin
        guard++;
        @(negedge clk);
      end
      if (if_stall) begin
        checks++;
        failures++;
        $display("FAIL fetch_timeout: if_stall still 1 after 100 cycles, required 0");
        if_vec_q.delete();
      end else begin
        if_done_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    if_req = 1'b0;
  endtask

  // Presents queued load/store vectors back to back, each held until done.
  task automatic run_data_side();
    int   guard;
    bus_t v;
    while (d_vec_q.size() > 0) begin
      v       = d_vec_q.pop_front();
      d_we    = v.we;
      d_addr  = v.addr;
      d_wdata = v.wdata;
      d_wmask = v.wmask;
      d_req   = 1'b1;
      guard   = 0;
      @(negedge clk);
      while (d_stall && guard < 100) begin
        guard++;
        @(negedge clk);
      end
      if (d_stall) begin
        checks++;
        failures++;
        $display("FAIL data_timeout: d_stall still 1 after 100 cycles, required 0");
        d_vec_q.delete();
      end else begin
        d_done_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    d_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 ns, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = 32'h0000_0000;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0000_0000;
    d_wdata = 32'h0000_0000; d_wmask = 4'h0; m_req_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_m_req_valid", m_req_valid, 1'b0);
    chk32("rst_m_addr", m_addr, 32'h0000_0000);
    chk32("rst_m_wdata", m_wdata, 32'h0000_0000);
    chk1("rst_m_we", m_we, 1'b0);
    chk32("rst_if_rdata", if_rdata, 32'h0000_0000);
    chk32("rst_d_rdata", d_rdata, 32'h0000_0000);
    chk1("rst_if_fault", if_fault, 1'b0);
    chk1("rst_d_err", d_err, 1'b0);
    chk1("rst_if_stall", if_stall, 1'b0);
    @(posedge clk); #1;
    d_req = 1'b1;
    @(negedge clk);
    chk1("rst_d_stall_held", d_stall, 1'b1);
    @(posedge clk); #1;
    d_req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single fetch at minimum latency
    exp_bus_q.push_back(mk_bus(1'b0, 32'h0000_1000, 32'h0, 4'h0));
    bus_rsp_q.push_back(mk_rsp(32'h0000_0013, 1'b0));
    exp_if_q.push_back(mk_cpl(32'h0000_0013, 1'b0, 1'b1));
    if_vec_q.push_back(32'h0000_1000);
    t0 = cyc;
    run_fetch_side();
    chk32("single_fetch_latency", if_done_cyc - t0, 32'd3);

    // Simultaneous store and fetch: store first, fetch four cycles later
    exp_bus_q.push_back(mk_bus(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF));
    exp_bus_q.push_back(mk_bus(1'b0, 32'h0000_1004, 32'h0, 4'h0));
    bus_rsp_q.push_back(mk_rsp(32'h1111_1111, 1'b0));
    bus_rsp_q.push_back(mk_rsp(32'h0000_0093, 1'b0));
    exp_d_q.push_back(mk_cpl(32'h0, 1'b0, 1'b0));
    exp_if_q.push_back(mk_cpl(32'h0000_0093, 1'b0, 1'b1));
    d_vec_q.push_back(mk_bus(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF));
    if_vec_q.push_back(32'h0000_1004);
    t0 = cyc;
    fork
      run_fetch_side();
      run_data_side();
    join
    chk32("both_data_latency", d_done_cyc - t0, 32'd3);
    chk32("both_fetch_latency", if_done_cyc - t0, 32'd7);

    // Starvation: order D0 D1 D2 D3 I0 D4 D5 I1
    for (int k = 0; k < 6; k++) begin
      d_vec_q.push_back(mk_bus(1'b0, 32'h0000_3000 + 32'(4 * k), 32'h0, 4'h0));
      exp_d_q.push_back(mk_cpl(32'hA000_0000 + 32'(k), 1'b0, 1'b1));
    end
    if_vec_q.push_back(32'h0000_1100);
    if_vec_q.push_back(32'h0000_1104);
    exp_if_q.push_back(mk_cpl(32'h0000_0033, 1'b0, 1'b1));
    exp_if_q.push_back(mk_cpl(32'h0000_0037, 1'b0, 1'b1));
    for (int k = 0; k < 4; k++) begin
      exp_bus_q.push_back(mk_bus(1'b0, 32'h0000_3000 + 32'(4 * k), 32'h0, 4'h0));
      bus_rsp_q.push_back(mk_rsp(32'hA000_0000 + 32'(k), 1'b0));
    end
    exp_bus_q.push_back(mk_bus(1'b0, 32'h0000_1100, 32'h0, 4'h0));
    bus_rsp_q.push_back(mk_rsp(32'h0000_0033, 1'b0));
    for (int k = 4; k < 6; k++) begin
      exp_bus_q.push_back(mk_bus(1'b0, 32'h0000_3000 + 32'(4 * k), 32'h0, 4'h0));
      bus_rsp_q.push_back(mk_rsp(32'hA000_0000 + 32'(k), 1'b0));
    end
    exp_bus_q.push_back(mk_bus(1'b0, 32'h0000_1104, 32'h0, 4'h0));
    bus_rsp_q.push_back(mk_rsp(32'h0000_0037, 1'b0));
    fork
      run_fetch_side();
      run_data_side();
    join

    // Timeout: no response, error completion 9 cycles after RSP entry
    rsp_mute = 1'b1;
    exp_bus_q.push_back(mk_bus(1'b0, 32'h0000_4000, 32'h0, 4'h0));
    exp_d_q.push_back(mk_cpl(32'h0000_0000, 1'b1, 1'b1));
    d_vec_q.push_back(mk_bus(1'b0, 32'h0000_4000, 32'h0, 4'h0));
    t0 = cyc;
    run_data_side();
    chk32("timeout_latency", d_done_cyc - t0, 32'd11);
    @(negedge clk);
    chk1("timeout_err_cleared_idle", d_err, 1'b0);
    chk32("timeout_rdata_hold", d_rdata, 32'h0000_0000);
    rsp_mute = 1'b0;
    @(posedge clk); #1;
    exp_bus_q.push_back(mk_bus(1'b0, 32'h0000_1200, 32'h0, 4'h0));
    bus_rsp_q.push_back(mk_rsp(32'h0000_0073, 1'b0));
    exp_if_q.push_back(mk_cpl(32'h0000_0073, 1'b0, 1'b1));
    if_vec_q.push_back(32'h0000_1200);
    t0 = cyc;
    run_fetch_side();
    chk32("after_timeout_latency", if_done_cyc - t0, 32'd3);

    // Flush: fetch dropped in RSP, DONE is silent; stale response ignored
    exp_bus_q.push_back(mk_bus(1'b0, 32'h0000_1300, 32'h0, 4'h0));
    bus_rsp_q.push_back(mk_rsp(32'hCAFE_0000, 1'b0));
    if_addr = 32'h0000_1300;
    if_req  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk32("flush_rdata_unchanged", if_rdata, 32'h0000_0073);
    chk1("flush_fault_clear", if_fault, 1'b0);
    stale_cnt++;
    @(negedge clk);
    @(negedge clk);
    chk1("stale_no_request", m_req_valid, 1'b0);
    chk32("stale_rdata_unchanged", if_rdata, 32'h0000_0073);
    chk1("stale_fault_clear", if_fault, 1'b0);
    @(posedge clk); #1;
    exp_bus_q.push_back(mk_bus(1'b0, 32'h0000_1400, 32'h0, 4'h0));
    bus_rsp_q.push_back(mk_rsp(32'h0000_0017, 1'b0));
    exp_if_q.push_back(mk_cpl(32'h0000_0017, 1'b0, 1'b1));
    if_vec_q.push_back(32'h0000_1400);
    t0 = cyc;
    run_fetch_side();
    chk32("after_flush_latency", if_done_cyc - t0, 32'd3);

    // Reset during REQ; the late response must be ignored
    exp_bus_q.push_back(mk_bus(1'b1, 32'h0000_5000, 32'h1234_5678, 4'h3));
    bus_rsp_q.push_back(mk_rsp(32'h5555_AAAA, 1'b0));
    d_we = 1'b1; d_addr = 32'h0000_5000; d_wdata = 32'h1234_5678; d_wmask = 4'h3;
    d_req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    d_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("midrst_m_req_valid", m_req_valid, 1'b0);
    chk32("midrst_m_addr", m_addr, 32'h0000_0000);
    chk1("midrst_m_we", m_we, 1'b0);
    chk32("midrst_m_wdata", m_wdata, 32'h0000_0000);
    chk32("midrst_m_wmask", {28'd0, m_wmask}, 32'h0000_0000);
    chk32("midrst_if_rdata", if_rdata, 32'h0000_0000);
    chk1("midrst_d_err", d_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    stale_cnt++;
    @(negedge clk);
    @(negedge clk);
    chk1("late_rsp_no_request", m_req_valid, 1'b0);
    chk32("late_rsp_d_rdata", d_rdata, 32'h0000_0000);
    chk1("late_rsp_d_err", d_err, 1'b0);

    // Normal load after reset, bus returns an error
    @(posedge clk); #1;
    exp_bus_q.push_back(mk_bus(1'b0, 32'h0000_6000, 32'h0, 4'h0));
    bus_rsp_q.push_back(mk_rsp(32'h6666_0001, 1'b1));
    exp_d_q.push_back(mk_cpl(32'h6666_0001, 1'b1, 1'b1));
    d_vec_q.push_back(mk_bus(1'b0, 32'h0000_6000, 32'h0, 4'h0));
    t0 = cyc;
    run_data_side();
    chk32("err_load_latency", d_done_cyc - t0, 32'd3);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk32("exp_bus_drained", exp_bus_q.size(), 32'd0);
    chk32("exp_if_drained", exp_if_q.size(), 32'd0);
    chk32("exp_d_drained", exp_d_q.size(), 32'd0);
    chk32("bus_rsp_drained", bus_rsp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
